ibex_sram_bank_bridge: RTL and testbench
========================================

Name: ibex_sram_bank_bridge

Overview:
- Connects the ibex instruction port and data port to NUM_BANKS single-port sky130 SRAM macros (32x256, 1rw, 1-cycle read latency).
- Replaces the hard-tied rvalid/fabric-driven gnt arrangement with a real req/gnt/rvalid protocol.
- Per-bank round-robin arbitration between the two masters.
- Out-of-range error response.
- Sits in the SoC top between ibex_core and the SRAM macro array, beside eFPGA_top.

Parameters:
- NUM_BANKS, 4, number of SRAM macros; power of two, 1..8.
- BANK_AW, 8, word-address width of one macro (256 words).
- BASE_ADDR, 32'h0000_0000, byte address of bank 0 word 0; must be aligned to NUM_BANKS*2^BANK_AW*4.

Ports:
- clk  in  1  system clock; also drives every macro clk0.
- resetn  in  1  asynchronous active-low reset.
- instr_req_i  in  1  instruction fetch request.
- instr_addr_i  in  32  byte address; bits [1:0] ignored.
- instr_gnt_o  out  1  request accepted this cycle.
- instr_rvalid_o  out  1  response valid.
- instr_rdata_o  out  32  read data.
- instr_err_o  out  1  out-of-range response, qualified by rvalid.
- data_req_i  in  1  data request.
- data_we_i  in  1  1 = write.
- data_be_i  in  4  byte enables.
- data_addr_i  in  32  byte address.
- data_wdata_i  in  32  write data.
- data_gnt_o  out  1  request accepted this cycle.
- data_rvalid_o  out  1  response valid.
- data_rdata_o  out  32  read data.
- data_err_o  out  1  out-of-range response.
- sram_csb_o  out  NUM_BANKS  per-bank chip select, active low.
- sram_web_o  out  NUM_BANKS  per-bank write enable, active low.
- sram_wmask_o  out  4*NUM_BANKS  per-bank write mask; bank b at [4b+:4].
- sram_addr_o  out  BANK_AW*NUM_BANKS  per-bank row address.
- sram_din_o  out  32*NUM_BANKS  per-bank write data.
- sram_dout_i  in  32*NUM_BANKS  per-bank read data, valid the cycle after an access.

Behaviour:
- Reset (resetn low, asynchronous):
  - All rvalid/err outputs 0; rdata outputs 0.
  - All gnt 0; sram_csb_o/sram_web_o all 1.
  - Every bank's round-robin pointer set to DATA.
  - gnt and csb are gated combinationally by resetn and by a registered run flag that goes 1 on the first clk edge after reset release. No access is issued while reset is asserted or in the release cycle.
- Decode:
  - off = addr - BASE_ADDR.
  - In range iff off < NUM_BANKS*2^BANK_AW*4.
  - bank = off[2+BANK_AW +: log2(NUM_BANKS)]; row = off[2 +: BANK_AW].
  - NUM_BANKS=1 uses bank 0.
- Grant (combinational, same cycle as req):
  - An out-of-range request is always granted and touches no bank.
  - In-range requests to different banks are both granted.
  - Same-bank requests: the master named by that bank's pointer is granted. The pointer then flips to the other master, and flips only on a conflict cycle.
  - The losing master keeps req high (ibex rule) and wins the next conflict.
- Bank drive: the winner drives csb=0, web=~we (instr always read), wmask=be (instr 4'hF), addr=row, din=wdata. Idle banks hold csb=1, web=1.
- Response:
  - Exactly one rvalid pulse in cycle N+1 for each gnt in cycle N.
  - Read: rdata = the granted bank's dout, using the bank index registered at grant.
  - Write: rdata = 0, err = 0.
  - Out of range: rdata = 0, err = 1; a write is dropped.
  - rdata and err are 0 whenever rvalid is 0.
- Throughput: one request per master per cycle (back-to-back grants allowed). Maximum outstanding is 1 per master, so no FIFO.
- Reset mid-operation: a pending rvalid is discarded and is not delivered after release.

Decomposition:
- Package/include mem_bridge_defs:
  - Master IDs MST_DATA=0, MST_INSTR=1.
  - clog2-style bank index width function.
  - SRAM word width constant 32.
- Sub-module mem_bank_rr_arb (one instance per bank): inputs two reqs, pointer register, outputs one-hot grant plus pointer update. Instantiated NUM_BANKS times via generate.

Test Plan:
- Reset, then data write 0xDEADBEEF to 0x204 with be=4'hF, then instr read 0x204. Expect bank 0 row 0x81 written; instr_rvalid one cycle after gnt with rdata 0xDEADBEEF and err=0.
- Same cycle: instr reads 0x000 and data reads 0x400 (banks 0 and 1). Expect both gnt in the same cycle and both rvalid in the next cycle.
- Three consecutive same-bank conflicts at 0x010 and 0x014 with both reqs held. Expect grants DATA, INSTR, DATA (pointer alternates) and every request answered exactly once.
- Data write be=4'b0010 with wdata 0x0000AB00 over existing 0x11223344 at 0x008, then read. Expect 0x1122AB44.
- Data read 0x1000 (just past 4 KiB). Expect gnt the same cycle, rvalid next cycle with err=1 and rdata=0, and all csb high. A write to 0x1000 leaves memory unchanged.
- Assert resetn low the cycle after a grant. Expect rvalid never asserted; after release, the first grant appears no earlier than the second clk edge.

Source files
------------

// File: rtl/ibex_sram_bank_bridge_pkg.sv
// mem_bridge_defs: shared constants for the ibex <-> SRAM bank bridge.
//   MST_DATA / MST_INSTR : master identifiers, also the encoding of the
//                          per-bank round-robin pointer.
//   SRAM_DW              : data width of one SRAM macro word.
//   bank_idx_w()         : width of a bank index (at least 1 bit).
package mem_bridge_defs;

  localparam logic MST_DATA  = 1'b0;
  localparam logic MST_INSTR = 1'b1;

  localparam int SRAM_DW = 32;

  function automatic int bank_idx_w(input int num_banks);
    int w;
    w = 1;
    while ((1 << w) < num_banks) w++;
    return w;
  endfunction

endpackage

// File: rtl/ibex_sram_bank_bridge_arb.sv
// mem_bank_rr_arb: two-master round-robin arbiter for one SRAM bank.
//   req_data, req_instr : bank requests from the data / instruction master
//   ptr                 : current pointer (master that wins the next conflict)
//   gnt_data, gnt_instr : one-hot (or zero) grant
//   ptr_nxt             : pointer value to register; changes only on a conflict
module mem_bank_rr_arb
  import mem_bridge_defs::*;
(
  input  logic req_data,
  input  logic req_instr,
  input  logic ptr,
  output logic gnt_data,
  output logic gnt_instr,
  output logic ptr_nxt
);

  always_comb begin
    gnt_data  = req_data;
    gnt_instr = req_instr;
    ptr_nxt   = ptr;
    if (req_data && req_instr) begin
      gnt_data  = (ptr == MST_DATA);
      gnt_instr = (ptr == MST_INSTR);
      ptr_nxt   = ~ptr;
    end
  end

endmodule

// File: rtl/ibex_sram_bank_bridge.sv
// ibex_sram_bank_bridge: connects the ibex instruction and data ports to
// NUM_BANKS single-port 32x256 SRAM macros with a req/gnt/rvalid protocol.
//   clk, resetn            : system clock, async active-low reset
//   instr_*                : ibex instruction port (read only)
//   data_*                 : ibex data port
//   sram_csb_o/web_o       : per-bank chip select / write enable, active low
//   sram_wmask_o           : per-bank byte mask, bank b at [4b+:4]
//   sram_addr_o/din_o      : per-bank row address / write data
//   sram_dout_i            : per-bank read data, valid the cycle after access
// Grants are combinational; every grant gets exactly one rvalid pulse in the
// following cycle. Out-of-range accesses are granted, touch no bank and
// return err=1.
module ibex_sram_bank_bridge
  import mem_bridge_defs::*;
#(
  parameter int          NUM_BANKS = 4,
  parameter int          BANK_AW   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         resetn,

  input  logic                         instr_req_i,
  input  logic [31:0]                  instr_addr_i,
  output logic                         instr_gnt_o,
  output logic                         instr_rvalid_o,
  output logic [31:0]                  instr_rdata_o,
  output logic                         instr_err_o,

  input  logic                         data_req_i,
  input  logic                         data_we_i,
  input  logic [3:0]                   data_be_i,
  input  logic [31:0]                  data_addr_i,
  input  logic [31:0]                  data_wdata_i,
  output logic                         data_gnt_o,
  output logic                         data_rvalid_o,
  output logic [31:0]                  data_rdata_o,
  output logic                         data_err_o,

  output logic [NUM_BANKS-1:0]         sram_csb_o,
  output logic [NUM_BANKS-1:0]         sram_web_o,
  output logic [4*NUM_BANKS-1:0]       sram_wmask_o,
  output logic [BANK_AW*NUM_BANKS-1:0] sram_addr_o,
  output logic [32*NUM_BANKS-1:0]      sram_din_o,
  input  logic [32*NUM_BANKS-1:0]      sram_dout_i
);

  localparam int          BIW  = bank_idx_w(NUM_BANKS);
  localparam logic [32:0] SPAN = 33'(NUM_BANKS) << (BANK_AW + 2);

  // run_q holds off all accesses through the reset-release cycle
  logic run_q;
  logic active;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) run_q <= 1'b0;
    else         run_q <= 1'b1;
  end

  assign active = resetn & run_q;

  // Address decode
  logic [31:0]        i_off, d_off;
  logic               i_inr, d_inr;
  logic [BIW-1:0]     i_bank, d_bank;
  logic [BANK_AW-1:0] i_row, d_row;

  assign i_off  = instr_addr_i - BASE_ADDR;
  assign d_off  = data_addr_i - BASE_ADDR;
  assign i_inr  = {1'b0, i_off} < SPAN;
  assign d_inr  = {1'b0, d_off} < SPAN;
  // masking keeps the single-bank case pinned to bank 0
  assign i_bank = i_off[BANK_AW+2 +: BIW] & BIW'(NUM_BANKS - 1);
  assign d_bank = d_off[BANK_AW+2 +: BIW] & BIW'(NUM_BANKS - 1);
  assign i_row  = i_off[2 +: BANK_AW];
  assign d_row  = d_off[2 +: BANK_AW];

  // Per-bank arbitration and macro drive
  logic [NUM_BANKS-1:0] g_data, g_instr, ptr_q, ptr_nxt;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic rq_d, rq_i;

    assign rq_d = active & data_req_i  & d_inr & (d_bank == BIW'(b));
    assign rq_i = active & instr_req_i & i_inr & (i_bank == BIW'(b));

    mem_bank_rr_arb u_arb (
      .req_data  (rq_d),
      .req_instr (rq_i),
      .ptr       (ptr_q[b]),
      .gnt_data  (g_data[b]),
      .gnt_instr (g_instr[b]),
      .ptr_nxt   (ptr_nxt[b])
    );

    assign sram_csb_o[b]                     = ~(g_data[b] | g_instr[b]);
    assign sram_web_o[b]                     = ~(g_data[b] & data_we_i);
    assign sram_wmask_o[4*b +: 4]            = g_data[b]  ? data_be_i :
                                               g_instr[b] ? 4'hF : 4'h0;
    assign sram_addr_o[BANK_AW*b +: BANK_AW] = g_data[b]  ? d_row :
                                               g_instr[b] ? i_row : '0;
    assign sram_din_o[32*b +: 32]            = g_data[b]  ? data_wdata_i : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ptr_q <= {NUM_BANKS{MST_DATA}};
    else         ptr_q <= ptr_nxt;
  end

  // Out-of-range requests never reach a bank but are still granted
  assign instr_gnt_o = active & instr_req_i & (~i_inr | (|g_instr));
  assign data_gnt_o  = active & data_req_i  & (~d_inr | (|g_data));

  // Response tracking: one outstanding access per master
  logic           i_rv, i_err, i_rd;
  logic           d_rv, d_err, d_rd;
  logic [BIW-1:0] i_bank_q, d_bank_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      i_rv     <= 1'b0;
      i_err    <= 1'b0;
      i_rd     <= 1'b0;
      i_bank_q <= '0;
      d_rv     <= 1'b0;
      d_err    <= 1'b0;
      d_rd     <= 1'b0;
      d_bank_q <= '0;
    end else begin
      i_rv     <= instr_gnt_o;
      i_err    <= instr_gnt_o & ~i_inr;
      i_rd     <= instr_gnt_o & i_inr;
      i_bank_q <= i_bank;
      d_rv     <= data_gnt_o;
      d_err    <= data_gnt_o & ~d_inr;
      d_rd     <= data_gnt_o & d_inr & ~data_we_i;
      d_bank_q <= d_bank;
    end
  end

  assign instr_rvalid_o = i_rv;
  assign instr_err_o    = i_rv & i_err;
  assign instr_rdata_o  = (i_rv & i_rd) ? sram_dout_i[SRAM_DW*i_bank_q +: SRAM_DW] : '0;

  assign data_rvalid_o  = d_rv;
  assign data_err_o     = d_rv & d_err;
  assign data_rdata_o   = (d_rv & d_rd) ? sram_dout_i[SRAM_DW*d_bank_q +: SRAM_DW] : '0;

endmodule

// File: tb/tb_ibex_sram_bank_bridge.sv
module tb_ibex_sram_bank_bridge;

  logic         clk;
  logic         resetn;
  logic         instr_req_i;
  logic [31:0]  instr_addr_i;
  logic         instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0]  instr_rdata_o;
  logic         data_req_i, data_we_i;
  logic [3:0]   data_be_i;
  logic [31:0]  data_addr_i, data_wdata_i;
  logic         data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0]  data_rdata_o;
  logic [3:0]   sram_csb_o, sram_web_o;
  logic [15:0]  sram_wmask_o;
  logic [31:0]  sram_addr_o;
  logic [127:0] sram_din_o, sram_dout_i;

  int n_cmp = 0;
  int n_bad = 0;

  ibex_sram_bank_bridge #(.NUM_BANKS(4), .BANK_AW(8), .BASE_ADDR(32'h0)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .instr_err_o    (instr_err_o),
    .data_req_i     (data_req_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .data_err_o     (data_err_o),
    .sram_csb_o     (sram_csb_o),
    .sram_web_o     (sram_web_o),
    .sram_wmask_o   (sram_wmask_o),
    .sram_addr_o    (sram_addr_o),
    .sram_din_o     (sram_din_o),
    .sram_dout_i    (sram_dout_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural 1rw SRAM macros, one-cycle read latency
  logic [31:0] mem [4][256];
  logic [31:0] dout [4];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (!sram_csb_o[b]) begin
        if (!sram_web_o[b]) begin
          for (int k = 0; k < 4; k++)
            if (sram_wmask_o[4*b+k])
              mem[b][sram_addr_o[8*b +: 8]][8*k +: 8] <= sram_din_o[32*b + 8*k +: 8];
        end
        dout[b] <= mem[b][sram_addr_o[8*b +: 8]];
      end
    end
  end

  assign sram_dout_i = {dout[3], dout[2], dout[1], dout[0]};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    data_req_i   = 1'b1;
    data_we_i    = 1'b1;
    data_be_i    = be;
    data_addr_i  = addr;
    data_wdata_i = wdata;
    tick();
    data_req_i = 1'b0;
    data_we_i  = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    resetn      = 1'b0;
    instr_req_i = 1'b1;
    data_req_i  = 1'b1;
    repeat (2) tick();
    #2;
    n_cmp++; if (instr_gnt_o !== 1'b0) begin n_bad++; $display("FAIL rst_instr_gnt got=%0h want=0", instr_gnt_o); end
    n_cmp++; if (data_gnt_o !== 1'b0) begin n_bad++; $display("FAIL rst_data_gnt got=%0h want=0", data_gnt_o); end
    n_cmp++; if (sram_csb_o !== 4'hF) begin n_bad++; $display("FAIL rst_csb got=%h want=f", sram_csb_o); end
    n_cmp++; if (sram_web_o !== 4'hF) begin n_bad++; $display("FAIL rst_web got=%h want=f", sram_web_o); end
    n_cmp++; if (instr_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid got=%b%b want=00", instr_rvalid_o, data_rvalid_o); end
    n_cmp++; if (instr_rdata_o !== 32'h0 || data_rdata_o !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got=%h/%h want=0", instr_rdata_o, data_rdata_o); end
    n_cmp++; if (instr_err_o !== 1'b0 || data_err_o !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%b%b want=00", instr_err_o, data_err_o); end
    tick();
    resetn = 1'b1;
    #2;
    n_cmp++; if (instr_gnt_o !== 1'b0 || data_gnt_o !== 1'b0) begin n_bad++; $display("FAIL release_cycle_gnt got=%b%b want=00", instr_gnt_o, data_gnt_o); end
    n_cmp++; if (sram_csb_o !== 4'hF) begin n_bad++; $display("FAIL release_cycle_csb got=%h want=f", sram_csb_o); end
    tick();
    n_cmp++; if (data_gnt_o !== 1'b1 || instr_gnt_o !== 1'b0) begin n_bad++; $display("FAIL post_release_ptr_data got d=%b i=%b want d=1 i=0", data_gnt_o, instr_gnt_o); end
    instr_req_i = 1'b0;
    data_req_i  = 1'b0;
    tick();
    n_cmp++; if (data_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL no_grant_no_rvalid got=%b want=0", data_rvalid_o); end
  endtask

  task automatic test_write_read();
    data_req_i   = 1'b1;
    data_we_i    = 1'b1;
    data_be_i    = 4'hF;
    data_addr_i  = 32'h204;
    data_wdata_i = 32'hDEADBEEF;
    #2;
    n_cmp++; if (data_gnt_o !== 1'b1) begin n_bad++; $display("FAIL wr_gnt got=%b want=1", data_gnt_o); end
    n_cmp++; if (sram_csb_o !== 4'b1110 || sram_web_o !== 4'b1110) begin n_bad++; $display("FAIL wr_csb_web got=%b/%b want=1110/1110", sram_csb_o, sram_web_o); end
    n_cmp++; if (sram_addr_o[7:0] !== 8'h81) begin n_bad++; $display("FAIL wr_row got=%h want=81", sram_addr_o[7:0]); end
    n_cmp++; if (sram_wmask_o[3:0] !== 4'hF) begin n_bad++; $display("FAIL wr_wmask got=%h want=f", sram_wmask_o[3:0]); end
    tick();
    data_req_i = 1'b0;
    data_we_i  = 1'b0;
    n_cmp++; if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h0 || data_err_o !== 1'b0) begin n_bad++; $display("FAIL wr_resp got rv=%b rd=%h err=%b want 1/0/0", data_rvalid_o, data_rdata_o, data_err_o); end
    n_cmp++; if (mem[0][8'h81] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_mem got=%h want=deadbeef", mem[0][8'h81]); end
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h204;
    #2;
    n_cmp++; if (instr_gnt_o !== 1'b1 || sram_web_o[0] !== 1'b1) begin n_bad++; $display("FAIL rd_gnt got gnt=%b web=%b want 1/1", instr_gnt_o, sram_web_o[0]); end
    tick();
    instr_req_i = 1'b0;
    n_cmp++; if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'hDEADBEEF || instr_err_o !== 1'b0) begin n_bad++; $display("FAIL rd_resp got rv=%b rd=%h err=%b want 1/deadbeef/0", instr_rvalid_o, instr_rdata_o, instr_err_o); end
    n_cmp++; if (data_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL wr_single_pulse got=%b want=0", data_rvalid_o); end
    tick();
    n_cmp++; if (instr_rvalid_o !== 1'b0 || instr_rdata_o !== 32'h0) begin n_bad++; $display("FAIL rd_single_pulse got rv=%b rd=%h want 0/0", instr_rvalid_o, instr_rdata_o); end
  endtask

  task automatic test_parallel();
    wr(32'h000, 32'h0A0A0A0A, 4'hF);
    wr(32'h400, 32'h1B1B1B1B, 4'hF);
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h000;
    data_req_i   = 1'b1;
    data_we_i    = 1'b0;
    data_addr_i  = 32'h400;
    #2;
    n_cmp++; if (instr_gnt_o !== 1'b1 || data_gnt_o !== 1'b1) begin n_bad++; $display("FAIL par_gnt got i=%b d=%b want 1/1", instr_gnt_o, data_gnt_o); end
    n_cmp++; if (sram_csb_o !== 4'b1100) begin n_bad++; $display("FAIL par_csb got=%b want=1100", sram_csb_o); end
    tick();
    instr_req_i = 1'b0;
    data_req_i  = 1'b0;
    n_cmp++; if (instr_rvalid_o !== 1'b1 || data_rvalid_o !== 1'b1) begin n_bad++; $display("FAIL par_rvalid got i=%b d=%b want 1/1", instr_rvalid_o, data_rvalid_o); end
    n_cmp++; if (instr_rdata_o !== 32'h0A0A0A0A) begin n_bad++; $display("FAIL par_instr_rdata got=%h want=0a0a0a0a", instr_rdata_o); end
    n_cmp++; if (data_rdata_o !== 32'h1B1B1B1B) begin n_bad++; $display("FAIL par_data_rdata got=%h want=1b1b1b1b", data_rdata_o); end
    tick();
  endtask

  task automatic test_conflict();
    bit [2:0] exp_d;
    exp_d = 3'b101;
    wr(32'h010, 32'h01010101, 4'hF);
    wr(32'h014, 32'h14141414, 4'hF);
    data_req_i   = 1'b1;
    data_we_i    = 1'b0;
    data_addr_i  = 32'h010;
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h014;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_cmp++; if (data_gnt_o !== exp_d[i] || instr_gnt_o !== ~exp_d[i]) begin n_bad++; $display("FAIL conflict_gnt[%0d] got d=%b i=%b want d=%b", i, data_gnt_o, instr_gnt_o, exp_d[i]); end
      tick();
      n_cmp++; if (data_rvalid_o !== exp_d[i] || instr_rvalid_o !== ~exp_d[i]) begin n_bad++; $display("FAIL conflict_rvalid[%0d] got d=%b i=%b want d=%b", i, data_rvalid_o, instr_rvalid_o, exp_d[i]); end
      if (exp_d[i]) begin
        n_cmp++; if (data_rdata_o !== 32'h01010101) begin n_bad++; $display("FAIL conflict_data_rdata[%0d] got=%h want=01010101", i, data_rdata_o); end
      end else begin
        n_cmp++; if (instr_rdata_o !== 32'h14141414) begin n_bad++; $display("FAIL conflict_instr_rdata[%0d] got=%h want=14141414", i, instr_rdata_o); end
      end
    end
    data_req_i = 1'b0;
    #2;
    n_cmp++; if (instr_gnt_o !== 1'b1 || data_gnt_o !== 1'b0) begin n_bad++; $display("FAIL conflict_tail_gnt got i=%b d=%b want 1/0", instr_gnt_o, data_gnt_o); end
    tick();
    instr_req_i = 1'b0;
    n_cmp++; if (instr_rvalid_o !== 1'b1 || data_rvalid_o !== 1'b0 || instr_rdata_o !== 32'h14141414) begin n_bad++; $display("FAIL conflict_tail_resp got i=%b d=%b rd=%h want 1/0/14141414", instr_rvalid_o, data_rvalid_o, instr_rdata_o); end
    tick();
  endtask

  task automatic test_byte_mask();
    wr(32'h008, 32'h11223344, 4'hF);
    data_req_i   = 1'b1;
    data_we_i    = 1'b1;
    data_be_i    = 4'b0010;
    data_addr_i  = 32'h008;
    data_wdata_i = 32'h0000AB00;
    #2;
    n_cmp++; if (sram_wmask_o[3:0] !== 4'b0010) begin n_bad++; $display("FAIL be_wmask got=%b want=0010", sram_wmask_o[3:0]); end
    tick();
    data_we_i = 1'b0;
    data_req_i = 1'b0;
    tick();
    data_req_i = 1'b1;
    tick();
    data_req_i = 1'b0;
    n_cmp++; if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h1122AB44) begin n_bad++; $display("FAIL be_readback got rv=%b rd=%h want 1/1122ab44", data_rvalid_o, data_rdata_o); end
    tick();
  endtask

  task automatic test_out_of_range();
    logic [31:0] snap;
    snap = mem[0][0];
    data_req_i  = 1'b1;
    data_we_i   = 1'b0;
    data_addr_i = 32'h1000;
    #2;
    n_cmp++; if (data_gnt_o !== 1'b1 || sram_csb_o !== 4'hF) begin n_bad++; $display("FAIL oor_rd_gnt got gnt=%b csb=%b want 1/1111", data_gnt_o, sram_csb_o); end
    tick();
    n_cmp++; if (data_rvalid_o !== 1'b1 || data_err_o !== 1'b1 || data_rdata_o !== 32'h0) begin n_bad++; $display("FAIL oor_rd_resp got rv=%b err=%b rd=%h want 1/1/0", data_rvalid_o, data_err_o, data_rdata_o); end
    data_we_i    = 1'b1;
    data_be_i    = 4'hF;
    data_wdata_i = 32'hCAFEF00D;
    #2;
    n_cmp++; if (data_gnt_o !== 1'b1 || sram_csb_o !== 4'hF) begin n_bad++; $display("FAIL oor_wr_gnt got gnt=%b csb=%b want 1/1111", data_gnt_o, sram_csb_o); end
    tick();
    data_req_i = 1'b0;
    data_we_i  = 1'b0;
    n_cmp++; if (data_rvalid_o !== 1'b1 || data_err_o !== 1'b1) begin n_bad++; $display("FAIL oor_wr_resp got rv=%b err=%b want 1/1", data_rvalid_o, data_err_o); end
    n_cmp++; if (mem[0][0] !== snap) begin n_bad++; $display("FAIL oor_wr_dropped got=%h want=%h", mem[0][0], snap); end
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h0FFC;
    #2;
    n_cmp++; if (instr_gnt_o !== 1'b1 || sram_csb_o !== 4'b0111 || sram_addr_o[31:24] !== 8'hFF) begin n_bad++; $display("FAIL last_word_drive got gnt=%b csb=%b row=%h want 1/0111/ff", instr_gnt_o, sram_csb_o, sram_addr_o[31:24]); end
    tick();
    instr_req_i = 1'b0;
    n_cmp++; if (instr_rvalid_o !== 1'b1 || instr_err_o !== 1'b0) begin n_bad++; $display("FAIL last_word_resp got rv=%b err=%b want 1/0", instr_rvalid_o, instr_err_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h204;
    #2;
    n_cmp++; if (instr_gnt_o !== 1'b1) begin n_bad++; $display("FAIL mid_gnt got=%b want=1", instr_gnt_o); end
    tick();
    resetn      = 1'b0;
    instr_req_i = 1'b0;
    #1;
    n_cmp++; if (instr_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL mid_rvalid_cleared got=%b want=0", instr_rvalid_o); end
    tick();
    n_cmp++; if (instr_rvalid_o !== 1'b0 || instr_rdata_o !== 32'h0) begin n_bad++; $display("FAIL mid_in_reset got rv=%b rd=%h want 0/0", instr_rvalid_o, instr_rdata_o); end
    instr_req_i  = 1'b1;
    data_req_i   = 1'b1;
    data_we_i    = 1'b0;
    data_addr_i  = 32'h200;
    resetn       = 1'b1;
    #2;
    n_cmp++; if (instr_gnt_o !== 1'b0 || data_gnt_o !== 1'b0) begin n_bad++; $display("FAIL mid_release_gnt got i=%b d=%b want 0/0", instr_gnt_o, data_gnt_o); end
    tick();
    n_cmp++; if (instr_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL mid_stale_rvalid got i=%b d=%b want 0/0", instr_rvalid_o, data_rvalid_o); end
    n_cmp++; if (data_gnt_o !== 1'b1 || instr_gnt_o !== 1'b0) begin n_bad++; $display("FAIL mid_ptr_reset got d=%b i=%b want 1/0", data_gnt_o, instr_gnt_o); end
    tick();
    data_req_i = 1'b0;
    n_cmp++; if (data_rvalid_o !== 1'b1 || data_rdata_o !== mem[0][8'h80]) begin n_bad++; $display("FAIL mid_data_resp got rv=%b rd=%h want 1/%h", data_rvalid_o, data_rdata_o, mem[0][8'h80]); end
    #2;
    n_cmp++; if (instr_gnt_o !== 1'b1) begin n_bad++; $display("FAIL mid_instr_regrant got=%b want=1", instr_gnt_o); end
    tick();
    instr_req_i = 1'b0;
    n_cmp++; if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL mid_instr_resp got rv=%b rd=%h want 1/deadbeef", instr_rvalid_o, instr_rdata_o); end
    tick();
  endtask

  initial begin
    resetn       = 1'b0;
    instr_req_i  = 1'b0;
    instr_addr_i = 32'h0;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = 4'h0;
    data_addr_i  = 32'h0;
    data_wdata_i = 32'h0;
    test_reset();
    test_write_read();
    test_parallel();
    test_conflict();
    test_byte_mask();
    test_out_of_range();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
